sprite_scheduler: RTL and testbench



---
 rtl/sprite_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sprite_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sprite_scheduler
// Purpose  : Per-frame erase/redraw pixel sequencer over NUM_OBJ object slots,
//            with stream backpressure and screen clipping.
// Option   : SPRITE_SKIP_UNCHANGED_EN skips slots unchanged since last frame.
// Revision : 1.0
// ---------------------------------------------------------------------------
module sprite_scheduler #(
  parameter int         NUM_OBJ   = 8,
  parameter int         XW        = 8,
  parameter int         YW        = 7,
  parameter int         SIZE      = 9,
  parameter int         X_MAX     = 160,
  parameter int         Y_MAX     = 120,
  parameter logic [2:0] BG_COLOUR = 3'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_req,
  output logic                    busy,
  output logic                    frame_done,
  input  logic [NUM_OBJ*XW-1:0]   obj_x,
  input  logic [NUM_OBJ*YW-1:0]   obj_y,
  input  logic [NUM_OBJ-1:0]      obj_e,
  input  logic [NUM_OBJ-1:0]      obj_big,
  input  logic [NUM_OBJ*3-1:0]    obj_colour,
  output logic [XW-1:0]           px_x,
  output logic [YW-1:0]           px_y,
  output logic [2:0]              px_colour,
  output logic                    px_valid,
  input  logic                    px_ready
);

  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OBJ - 1);
  localparam logic [CW-1:0] LAST_OFF = CW'(SIZE - 1);
  localparam logic [XW:0]   X_LIM    = (XW+1)'(X_MAX);
  localparam logic [YW:0]   Y_LIM    = (YW+1)'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_ERASE, S_DRAW, S_ADV, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   dx, dx_n, dy, dy_n;
  logic [XW-1:0]   cur_x, cur_x_n;
  logic [YW-1:0]   cur_y, cur_y_n;
  logic            cur_e, cur_e_n, cur_big, cur_big_n;
  logic [2:0]      cur_colour, cur_colour_n;
  logic            need_draw, need_draw_n;
  logic            busy_n, done_n, valid_n;
  logic [XW-1:0]   px_x_n;
  logic [YW-1:0]   px_y_n;
  logic [2:0]      px_colour_n;

  logic [XW-1:0]   prev_x [NUM_OBJ];
  logic [YW-1:0]   prev_y [NUM_OBJ];
  logic [NUM_OBJ-1:0] prev_e, prev_big;
  logic [2:0]      prev_colour [NUM_OBJ];

  logic [XW-1:0]   sel_x, tgt_x;
  logic [YW-1:0]   sel_y, tgt_y;
  logic [2:0]      sel_colour, tgt_colour;
  logic            sel_e, sel_big;
  logic            load_px, commit, need_erase, need_draw_sel, scan_big;
  logic [CW-1:0]   scan_last;
  logic [XW:0]     sum_x;
  logic [YW:0]     sum_y;

  assign sel_x      = obj_x[idx*XW +: XW];
  assign sel_y      = obj_y[idx*YW +: YW];
  assign sel_colour = obj_colour[idx*3 +: 3];
  assign sel_e      = obj_e[idx];
  assign sel_big    = obj_big[idx];

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    dx_n          = dx;
    dy_n          = dy;
    cur_x_n       = cur_x;
    cur_y_n       = cur_y;
    cur_e_n       = cur_e;
    cur_big_n     = cur_big;
    cur_colour_n  = cur_colour;
    need_draw_n   = need_draw;
    busy_n        = busy;
    done_n        = 1'b0;
    valid_n       = px_valid;
    load_px       = 1'b0;
    commit        = 1'b0;
    need_erase    = 1'b0;
    need_draw_sel = 1'b0;
    scan_big      = 1'b0;
    scan_last     = '0;
    tgt_x         = cur_x;
    tgt_y         = cur_y;
    tgt_colour    = cur_colour;

    case (state)
      S_IDLE: begin
        if (frame_req) begin
          idx_n   = '0;
          busy_n  = 1'b1;
          state_n = S_SEL;
        end
      end
      S_SEL: begin
        cur_x_n       = sel_x;
        cur_y_n       = sel_y;
        cur_e_n       = sel_e;
        cur_big_n     = sel_big;
        cur_colour_n  = sel_colour;
        need_erase    = prev_e[idx];
        need_draw_sel = sel_e;
`ifdef SPRITE_SKIP_UNCHANGED_EN
        if (sel_x == prev_x[idx] && sel_y == prev_y[idx] && sel_e == prev_e[idx] &&
            sel_big == prev_big[idx] && sel_colour == prev_colour[idx]) begin
          need_erase    = 1'b0;
          need_draw_sel = 1'b0;
        end
`endif
        need_draw_n = need_draw_sel;
        dx_n        = '0;
        dy_n        = '0;
        if (need_erase) begin
          state_n    = S_ERASE;
          load_px    = 1'b1;
          tgt_x      = prev_x[idx];
          tgt_y      = prev_y[idx];
          tgt_colour = BG_COLOUR;
        end else if (need_draw_sel) begin
          state_n    = S_DRAW;
          load_px    = 1'b1;
          tgt_x      = sel_x;
          tgt_y      = sel_y;
          tgt_colour = sel_colour;
        end else begin
          state_n = S_ADV;
        end
      end
      S_ERASE, S_DRAW: begin
        scan_big  = (state == S_ERASE) ? prev_big[idx] : cur_big;
        scan_last = scan_big ? LAST_OFF : '0;
        if (state == S_ERASE) begin
          tgt_x      = prev_x[idx];
          tgt_y      = prev_y[idx];
          tgt_colour = BG_COLOUR;
        end
        // A clipped pixel is never offered, so it always moves on after one cycle.
        if (!px_valid || px_ready) begin
          if (dx == scan_last && dy == scan_last) begin
            valid_n = 1'b0;
            dx_n    = '0;
            dy_n    = '0;
            if (state == S_ERASE && need_draw) begin
              state_n    = S_DRAW;
              load_px    = 1'b1;
              tgt_x      = cur_x;
              tgt_y      = cur_y;
              tgt_colour = cur_colour;
            end else begin
              state_n = S_ADV;
            end
          end else begin
            load_px = 1'b1;
            if (dx == scan_last) begin
              dx_n = '0;
              dy_n = dy + 1'b1;
            end else begin
              dx_n = dx + 1'b1;
            end
          end
        end
      end
      S_ADV: begin
        commit = 1'b1;
        if (idx == LAST_IDX) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = S_SEL;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Clip on the untruncated coordinate so off-screen pixels never wrap back on.
    sum_x = {1'b0, tgt_x} + (XW+1)'(dx_n);
    sum_y = {1'b0, tgt_y} + (YW+1)'(dy_n);
    if (load_px) valid_n = (sum_x < X_LIM) && (sum_y < Y_LIM);
    px_x_n      = load_px ? sum_x[XW-1:0] : px_x;
    px_y_n      = load_px ? sum_y[YW-1:0] : px_y;
    px_colour_n = load_px ? tgt_colour : px_colour;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      dx         <= '0;
      dy         <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_e      <= 1'b0;
      cur_big    <= 1'b0;
      cur_colour <= 3'd0;
      need_draw  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      px_valid   <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      px_colour  <= 3'd0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      dx         <= dx_n;
      dy         <= dy_n;
      cur_x      <= cur_x_n;
      cur_y      <= cur_y_n;
      cur_e      <= cur_e_n;
      cur_big    <= cur_big_n;
      cur_colour <= cur_colour_n;
      need_draw  <= need_draw_n;
      busy       <= busy_n;
      frame_done <= done_n;
      px_valid   <= valid_n;
      px_x       <= px_x_n;
      px_y       <= px_y_n;
      px_colour  <= px_colour_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_e   <= '0;
      prev_big <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        prev_x[i]      <= '0;
        prev_y[i]      <= '0;
        prev_colour[i] <= 3'd0;
      end
    end else if (commit) begin
      prev_x[idx]      <= cur_x;
      prev_y[idx]      <= cur_y;
      prev_e[idx]      <= cur_e;
      prev_big[idx]    <= cur_big;
      prev_colour[idx] <= cur_colour;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_sprite_scheduler
// Purpose  : Directed self-checking bench for sprite_scheduler (two slots).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_sprite_scheduler;

  localparam int NUM_OBJ = 2;
  localparam int XW      = 8;
  localparam int YW      = 7;

  logic                  clk = 1'b0;
  logic                  reset, frame_req, busy, frame_done;
  logic [NUM_OBJ*XW-1:0] obj_x;
  logic [NUM_OBJ*YW-1:0] obj_y;
  logic [NUM_OBJ-1:0]    obj_e, obj_big;
  logic [NUM_OBJ*3-1:0]  obj_colour;
  logic [XW-1:0]         px_x;
  logic [YW-1:0]         px_y;
  logic [2:0]            px_colour;
  logic                  px_valid, px_ready;

  sprite_scheduler #(.NUM_OBJ(NUM_OBJ), .XW(XW), .YW(YW)) dut (
    .clk(clk), .reset(reset), .frame_req(frame_req), .busy(busy),
    .frame_done(frame_done), .obj_x(obj_x), .obj_y(obj_y), .obj_e(obj_e),
    .obj_big(obj_big), .obj_colour(obj_colour), .px_x(px_x), .px_y(px_y),
    .px_colour(px_colour), .px_valid(px_valid), .px_ready(px_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    c;
  } pix_t;

  pix_t got_q[$];
  pix_t exp_q[$];
  pix_t hold_p;
  int   cyc = 0, done_cnt = 0, done_cyc = 0, hold_err = 0, req_cyc = 0;
  logic done_busy = 1'b0, stall_d = 1'b0;
  int   checks = 0, passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stall_d && (!px_valid || {px_x, px_y, px_colour} != hold_p)) hold_err++;
    stall_d = px_valid && !px_ready;
    hold_p  = {px_x, px_y, px_colour};
    if (px_valid && px_ready) got_q.push_back({px_x, px_y, px_colour});
    if (frame_done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_slot0(input int x, input int y, input bit e, input bit big, input int c);
    obj_x[XW-1:0]  = XW'(x);
    obj_y[YW-1:0]  = YW'(y);
    obj_e[0]       = e;
    obj_big[0]     = big;
    obj_colour[2:0] = 3'(c);
  endtask

  // Row-major reference scan with on-screen filtering.
  task automatic add_box(input int x, input int y, input bit big, input int c);
    int w = big ? 9 : 1;
    for (int yy = 0; yy < w; yy++)
      for (int xx = 0; xx < w; xx++)
        if (x + xx < 160 && y + yy < 120)
          exp_q.push_back({XW'(x + xx), YW'(y + yy), 3'(c)});
  endtask

  task automatic compare_pixels(input string tag, input int base);
    int errs = 0;
    int n    = got_q.size() - base;
    check({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= n || got_q[base + i] != exp_q[i]) errs++;
    check({tag, "_order"}, errs, 0);
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input bit pat, output int delay);
    int start = done_cnt;
    bit ok    = 1'b0;
    @(posedge clk); #1;
    frame_req = 1'b1;
    req_cyc   = cyc;
    @(posedge clk); #1;
    frame_req = 1'b0;
    for (int k = 1; k < 4000; k++) begin
      if (pat) px_ready = (k % 4 == 0) || (k % 4 == 3);
      @(negedge clk);
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    px_ready = 1'b1;
    check({tag, "_done_seen"}, int'(ok), 1);
    delay = done_cyc - req_cyc;
  endtask

  initial begin
    int base, d, dc;
    reset = 1'b1; frame_req = 1'b0; px_ready = 1'b1;
    obj_x = '0; obj_y = '0; obj_e = '0; obj_big = '0; obj_colour = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_px_valid", int'(px_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_px_x", int'(px_x), 0);
    check("rst_px_y", int'(px_y), 0);
    check("rst_px_colour", int'(px_colour), 0);
    reset = 1'b0;

    // Frame 1: single big object, nothing to erase yet.
    set_slot0(10, 5, 1, 1, 1);
    base = got_q.size();
    run_frame("f1", 1'b0, d);
    add_box(10, 5, 1, 1);
    compare_pixels("f1", base);
    check("f1_done_delay", d, 86);
    check("f1_busy_at_done", int'(done_busy), 0);

    // Frame 2: moved by one pixel, erase then redraw.
    set_slot0(11, 5, 1, 1, 1);
    base = got_q.size();
    run_frame("f2", 1'b0, d);
    add_box(10, 5, 1, 0);
    add_box(11, 5, 1, 1);
    compare_pixels("f2", base);
    check("f2_done_delay", d, 167);

    // Frame 3: unchanged snapshot.
    base = got_q.size();
    run_frame("f3", 1'b0, d);
`ifdef SPRITE_SKIP_UNCHANGED_EN
    check("f3_done_delay", d, 5);
`else
    add_box(11, 5, 1, 0);
    add_box(11, 5, 1, 1);
    check("f3_done_delay", d, 167);
`endif
    compare_pixels("f3", base);

    // Frame 4: backpressure pattern 1,0,0,1 throughout.
    set_slot0(12, 6, 1, 1, 2);
    base = got_q.size();
    hold_err = 0;
    run_frame("f4", 1'b1, d);
    add_box(11, 5, 1, 0);
    add_box(12, 6, 1, 2);
    compare_pixels("f4", base);
    check("f4_hold_stable", hold_err, 0);

    // Frame 5: box straddling the bottom-right screen edge.
    set_slot0(155, 115, 1, 1, 3);
    base = got_q.size();
    run_frame("f5", 1'b0, d);
    add_box(12, 6, 1, 0);
    add_box(155, 115, 1, 3);
    compare_pixels("f5", base);
    check("f5_done_delay", d, 167);

    // Frame 6: reset asserted mid-DRAW.
    set_slot0(20, 20, 1, 1, 5);
    dc = done_cnt;
    @(posedge clk); #1;
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
    repeat (89) @(posedge clk);
    #1;
    check("f6_valid_in_draw", int'(px_valid), 1);
    check("f6_busy_in_draw", int'(busy), 1);
    check("f6_colour_in_draw", int'(px_colour), 5);
    reset = 1'b1;
    @(posedge clk); #1;
    check("f6_valid_after_rst", int'(px_valid), 0);
    check("f6_busy_after_rst", int'(busy), 0);
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("f6_no_frame_done", done_cnt, dc);

    // Frame 7: prev state was wiped, so draw only.
    base = got_q.size();
    run_frame("f7", 1'b0, d);
    add_box(20, 20, 1, 5);
    compare_pixels("f7", base);
    check("f7_done_delay", d, 86);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
